// File: rtl/ambient_pkg.sv
// ambient_pkg: shared state encoding, default widths/thresholds and helpers for the zone controller.
package ambient_pkg;
   typedef enum logic [1:0] {ST_OFF, ST_IDLE, ST_CONTROL} state_t;
   localparam int TEMP_W_DEF  = 6;
   localparam int HUM_W_DEF   = 7;
   localparam int LUM_W_DEF   = 10;
   localparam int T_HEAT_ON_DEF  = 20;
   localparam int T_HEAT_OFF_DEF = 22;
   localparam int T_AC_ON_DEF    = 25;
   localparam int T_AC_OFF_DEF   = 22;
   localparam int H_DH_ON_DEF    = 50;
   localparam int H_DH_OFF_DEF   = 35;
   localparam int L_BL_ON_DEF    = 700;
   localparam int L_BL_OFF_DEF   = 200;
   localparam int HOLD_W = 8;

   function automatic int zw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // set wins over clear; neither keeps the current value
   function automatic logic hyst(input logic cur, input logic set, input logic clr);
      return set | (cur & ~clr);
   endfunction
endpackage

// File: rtl/ambient_zone_ch.sv
// ambient_zone_ch: one zone's four actuator bits, hysteresis decisions and minimum-hold counter.
module ambient_zone_ch import ambient_pkg::*; #(
   parameter int TEMP_W     = TEMP_W_DEF,
   parameter int HUM_W      = HUM_W_DEF,
   parameter int LUM_W      = LUM_W_DEF,
   parameter int MIN_HOLD   = 8,
   parameter int T_HEAT_ON  = T_HEAT_ON_DEF,
   parameter int T_HEAT_OFF = T_HEAT_OFF_DEF,
   parameter int T_AC_ON    = T_AC_ON_DEF,
   parameter int T_AC_OFF   = T_AC_OFF_DEF,
   parameter int H_DH_ON    = H_DH_ON_DEF,
   parameter int H_DH_OFF   = H_DH_OFF_DEF,
   parameter int L_BL_ON    = L_BL_ON_DEF,
   parameter int L_BL_OFF   = L_BL_OFF_DEF
) (
   input  logic              clk_i,
   input  logic              reset_n,
   input  logic              clr_i,
   input  logic              upd_i,
   input  logic [TEMP_W-1:0] temp_i,
   input  logic [HUM_W-1:0]  hum_i,
   input  logic [LUM_W-1:0]  lum_i,
   output logic              heat_o,
   output logic              ac_o,
   output logic              dh_o,
   output logic              bl_o
);
   localparam logic [TEMP_W-1:0] c_heat_on  = TEMP_W'(T_HEAT_ON);
   localparam logic [TEMP_W-1:0] c_heat_off = TEMP_W'(T_HEAT_OFF);
   localparam logic [TEMP_W-1:0] c_ac_on    = TEMP_W'(T_AC_ON);
   localparam logic [TEMP_W-1:0] c_ac_off   = TEMP_W'(T_AC_OFF);
   localparam logic [HUM_W-1:0]  c_dh_on    = HUM_W'(H_DH_ON);
   localparam logic [HUM_W-1:0]  c_dh_off   = HUM_W'(H_DH_OFF);
   localparam logic [LUM_W-1:0]  c_bl_on    = LUM_W'(L_BL_ON);
   localparam logic [LUM_W-1:0]  c_bl_off   = LUM_W'(L_BL_OFF);

   logic [HOLD_W-1:0] r_cnt;
   logic w_heat, w_ac, w_dh, w_bl, w_go, w_chg;

   always_comb begin
      w_ac   = hyst(ac_o, temp_i >= c_ac_on, temp_i <= c_ac_off);
      w_heat = hyst(heat_o, temp_i < c_heat_on, temp_i >= c_heat_off) & ~w_ac;
      w_dh   = hyst(dh_o, hum_i >= c_dh_on, hum_i <= c_dh_off);
      w_bl   = hyst(bl_o, lum_i >= c_bl_on, lum_i <= c_bl_off);
      w_go   = upd_i && (r_cnt == '0);
      w_chg  = w_go && ({w_heat, w_ac, w_dh, w_bl} != {heat_o, ac_o, dh_o, bl_o});
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         {heat_o, ac_o, dh_o, bl_o} <= '0;
         r_cnt <= '0;
      end else if (clr_i) begin
         {heat_o, ac_o, dh_o, bl_o} <= '0;
         r_cnt <= '0;
      end else begin
         if (w_go) {heat_o, ac_o, dh_o, bl_o} <= {w_heat, w_ac, w_dh, w_bl};
         r_cnt <= w_chg ? HOLD_W'(MIN_HOLD) : r_cnt - HOLD_W'(r_cnt != '0);
      end
   end
endmodule

// File: rtl/ambient_zone_ctrl.sv
// ambient_zone_ctrl: OFF/IDLE/CONTROL sequencer that captures one sample and applies it to the addressed zone.
module ambient_zone_ctrl import ambient_pkg::*; #(
   parameter int NUM_ZONES  = 4,
   parameter int TEMP_W     = TEMP_W_DEF,
   parameter int HUM_W      = HUM_W_DEF,
   parameter int LUM_W      = LUM_W_DEF,
   parameter int MIN_HOLD   = 8,
   parameter int T_HEAT_ON  = T_HEAT_ON_DEF,
   parameter int T_HEAT_OFF = T_HEAT_OFF_DEF,
   parameter int T_AC_ON    = T_AC_ON_DEF,
   parameter int T_AC_OFF   = T_AC_OFF_DEF,
   parameter int H_DH_ON    = H_DH_ON_DEF,
   parameter int H_DH_OFF   = H_DH_OFF_DEF,
   parameter int L_BL_ON    = L_BL_ON_DEF,
   parameter int L_BL_OFF   = L_BL_OFF_DEF
) (
   input  logic                        clk_i,
   input  logic                        reset_n,
   input  logic                        enable_i,
   input  logic                        valid_i,
   input  logic [zw(NUM_ZONES)-1:0]    zone_i,
   input  logic [TEMP_W-1:0]           temperature_i,
   input  logic [HUM_W-1:0]            humidity_i,
   input  logic [LUM_W-1:0]            luminous_intensity_i,
   output logic                        ready_o,
   output logic [NUM_ZONES-1:0]        heat_o,
   output logic [NUM_ZONES-1:0]        AC_o,
   output logic [NUM_ZONES-1:0]        dehumidifier_o,
   output logic [NUM_ZONES-1:0]        blinds_o,
   output logic                        done_o,
   output logic                        err_o
);
   localparam int ZW = zw(NUM_ZONES);

   state_t            r_state, w_next;
   logic [ZW-1:0]     r_zone;
   logic [TEMP_W-1:0] r_temp;
   logic [HUM_W-1:0]  r_hum;
   logic [LUM_W-1:0]  r_lum;
   logic              r_done, r_err;
   logic              w_hs, w_upd, w_zok;

   assign ready_o = (r_state == ST_IDLE);
   assign done_o  = r_done;
   assign err_o   = r_err;

   always_comb begin
      w_next = r_state;
      if (!enable_i) w_next = ST_OFF;
      else if (r_state != ST_IDLE) w_next = ST_IDLE;
      else if (valid_i) w_next = ST_CONTROL;
      w_hs  = enable_i && valid_i && ready_o;
      w_upd = enable_i && (r_state == ST_CONTROL);
      w_zok = {1'b0, r_zone} < (ZW + 1)'(NUM_ZONES);
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_OFF;
         {r_zone, r_temp, r_hum, r_lum, r_done, r_err} <= '0;
      end else begin
         r_state <= w_next;
         if (!enable_i) {r_zone, r_temp, r_hum, r_lum} <= '0;
         else if (w_hs) {r_zone, r_temp, r_hum, r_lum} <= {zone_i, temperature_i, humidity_i, luminous_intensity_i};
         r_done <= w_upd && w_zok;
         r_err  <= w_upd && !w_zok;
      end
   end

   for (genvar g = 0; g < NUM_ZONES; g++) begin : g_zone
      ambient_zone_ch #(
         .TEMP_W(TEMP_W), .HUM_W(HUM_W), .LUM_W(LUM_W), .MIN_HOLD(MIN_HOLD),
         .T_HEAT_ON(T_HEAT_ON), .T_HEAT_OFF(T_HEAT_OFF), .T_AC_ON(T_AC_ON), .T_AC_OFF(T_AC_OFF),
         .H_DH_ON(H_DH_ON), .H_DH_OFF(H_DH_OFF), .L_BL_ON(L_BL_ON), .L_BL_OFF(L_BL_OFF)
      ) u_ch (
         .clk_i  (clk_i),
         .reset_n(reset_n),
         .clr_i  (!enable_i),
         .upd_i  (w_upd && (r_zone == ZW'(g))),
         .temp_i (r_temp),
         .hum_i  (r_hum),
         .lum_i  (r_lum),
         .heat_o (heat_o[g]),
         .ac_o   (AC_o[g]),
         .dh_o   (dehumidifier_o[g]),
         .bl_o   (blinds_o[g])
      );
   end
endmodule

// File: tb/tb_ambient_zone_ctrl.sv
// tb_ambient_zone_ctrl: directed and randomized checks of the zone controller against a per-zone timestamp model.
module tb_ambient_zone_ctrl;
   localparam int NZ = 3;
   localparam int MH = 8;

   logic       clk_i = 0, reset_n = 0, enable_i = 0, valid_i = 0;
   logic [1:0] zone_i = 0;
   logic [5:0] temperature_i = 0;
   logic [6:0] humidity_i = 0;
   logic [9:0] luminous_intensity_i = 0;
   logic       ready_o, done_o, err_o;
   logic [NZ-1:0] heat_o, AC_o, dehumidifier_o, blinds_o;

   int n_vec = 0, n_bad = 0, cyc = 0;
   int m_heat[NZ], m_ac[NZ], m_dh[NZ], m_bl[NZ], m_last[NZ];
   int e_done, e_err;

   ambient_zone_ctrl #(.NUM_ZONES(NZ), .MIN_HOLD(MH)) dut (
      .clk_i(clk_i), .reset_n(reset_n), .enable_i(enable_i), .valid_i(valid_i),
      .zone_i(zone_i), .temperature_i(temperature_i), .humidity_i(humidity_i),
      .luminous_intensity_i(luminous_intensity_i), .ready_o(ready_o),
      .heat_o(heat_o), .AC_o(AC_o), .dehumidifier_o(dehumidifier_o), .blinds_o(blinds_o),
      .done_o(done_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [NZ-1:0] vec(input int sel);
      logic [NZ-1:0] v;
      for (int z = 0; z < NZ; z++)
         v[z] = (sel == 0) ? m_heat[z] != 0 : (sel == 1) ? m_ac[z] != 0 : (sel == 2) ? m_dh[z] != 0 : m_bl[z] != 0;
      return v;
   endfunction

   task automatic check_outs(input string tag);
      check({tag, " heat"}, 32'(heat_o), 32'(vec(0)));
      check({tag, " ac"}, 32'(AC_o), 32'(vec(1)));
      check({tag, " dehum"}, 32'(dehumidifier_o), 32'(vec(2)));
      check({tag, " blinds"}, 32'(blinds_o), 32'(vec(3)));
   endtask

   task automatic model_clr();
      for (int z = 0; z < NZ; z++) begin
         m_heat[z] = 0; m_ac[z] = 0; m_dh[z] = 0; m_bl[z] = 0; m_last[z] = -1000;
      end
   endtask

   // a zone may change only if more than MH edges have passed since its last change
   task automatic model_apply(input int z, input int t, input int h, input int l, input int u);
      int a, ht, d, b;
      e_done = (z < NZ);
      e_err  = (z >= NZ);
      if (z < NZ && u - m_last[z] > MH) begin
         a  = t >= 25 ? 1 : t <= 22 ? 0 : m_ac[z];
         ht = t < 20 ? 1 : t >= 22 ? 0 : m_heat[z];
         if (a != 0) ht = 0;
         d  = h >= 50 ? 1 : h <= 35 ? 0 : m_dh[z];
         b  = l >= 700 ? 1 : l <= 200 ? 0 : m_bl[z];
         if (a != m_ac[z] || ht != m_heat[z] || d != m_dh[z] || b != m_bl[z]) m_last[z] = u;
         m_ac[z] = a; m_heat[z] = ht; m_dh[z] = d; m_bl[z] = b;
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         tick();
         @(negedge clk_i);
      end
   endtask

   // called and returns at a negedge with the DUT expected in IDLE
   task automatic send(input int z, input int t, input int h, input int l, input bit abort);
      check("ready idle", 32'(ready_o), 1);
      valid_i = 1; zone_i = 2'(z); temperature_i = 6'(t); humidity_i = 7'(h); luminous_intensity_i = 10'(l);
      tick();
      @(negedge clk_i);
      valid_i = 0;
      check("ready control", 32'(ready_o), 0);
      if (abort) begin
         enable_i = 0;
         tick();
         @(negedge clk_i);
         model_clr();
         check("abort done", 32'(done_o), 0);
         check("abort err", 32'(err_o), 0);
         check("abort ready", 32'(ready_o), 0);
         check_outs("abort");
         enable_i = 1;
         tick();
         @(negedge clk_i);
         check("reenable ready", 32'(ready_o), 1);
      end else begin
         tick();
         model_apply(z, t, h, l, cyc);
         @(negedge clk_i);
         check("done", 32'(done_o), 32'(e_done));
         check("err", 32'(err_o), 32'(e_err));
         check_outs("update");
      end
   endtask

   initial begin
      model_clr();
      repeat (2) @(negedge clk_i);
      check("rst ready", 32'(ready_o), 0);
      check("rst done", 32'(done_o), 0);
      check_outs("rst");
      reset_n = 1;
      idle(3);
      check("off without enable", 32'(ready_o), 0);
      enable_i = 1;
      idle(1);
      check("enabled ready", 32'(ready_o), 1);

      send(1, 18, 40, 300, 0);
      check("heat zone1", 32'(heat_o), 32'b010);
      idle(10);
      send(1, 21, 40, 300, 0);
      idle(10);
      send(1, 22, 40, 300, 0);
      send(2, 30, 40, 300, 0);
      send(2, 10, 40, 300, 0);
      check("ac zone2 held", 32'(AC_o[2]), 1);
      idle(2);
      send(0, 20, 50, 700, 0);
      idle(10);
      send(0, 20, 36, 201, 0);
      send(3, 5, 60, 900, 0);
      send(1, 40, 60, 900, 1);

      idle(10);
      send(0, 10, 60, 900, 0);
      check("zone0 heat set", 32'(heat_o[0]), 1);
      valid_i = 1; zone_i = 1; temperature_i = 30;
      tick();
      @(negedge clk_i);
      valid_i = 0;
      reset_n = 0;
      #1;
      model_clr();
      check("async rst ready", 32'(ready_o), 0);
      check("async rst done", 32'(done_o), 0);
      check_outs("async rst");
      @(negedge clk_i);
      reset_n = 1;
      #1;
      check("post rst ready", 32'(ready_o), 0);
      @(negedge clk_i);
      tick();
      @(negedge clk_i);
      check("post rst enabled", 32'(ready_o), 1);

      for (int i = 0; i < 200; i++) begin
         send($urandom_range(0, 3), $urandom_range(5, 35), $urandom_range(25, 60),
              $urandom_range(100, 800), $urandom_range(0, 19) == 0);
         idle($urandom_range(0, 12));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/ambient_zone_ctrl.md
AMBIENT_ZONE_CTRL -- requirements
Module: ambient_zone_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  NUM_ZONES, 4, number of independently controlled zones (1..16)
  TEMP_W, 6, temperature sample width
  HUM_W, 7, humidity sample width
  LUM_W, 10, luminous-intensity sample width
  MIN_HOLD, 8, minimum cycles between actuator changes in one zone (1..255)
  T_HEAT_ON / T_HEAT_OFF, 20 / 22, heater on below / off at-or-above
  T_AC_ON / T_AC_OFF, 25 / 22, AC on at-or-above / off at-or-below
  H_DH_ON / H_DH_OFF, 50 / 35, dehumidifier on at-or-above / off at-or-below
  L_BL_ON / L_BL_OFF, 700 / 200, blinds on at-or-above / off at-or-below
REQ-002 SHALL have ports, one per line: name, direction, width, meaning; ZW = max(1, clog2(NUM_ZONES)).
  clk_i  in  1  single clock, rising edge
  reset_n  in  1  asynchronous, active-low reset
  enable_i  in  1  block enable; low forces OFF
  valid_i  in  1  sample valid
  zone_i  in  ZW  zone index of sample
  temperature_i  in  TEMP_W  unsigned temperature
  humidity_i  in  HUM_W  unsigned humidity
  luminous_intensity_i  in  LUM_W  unsigned intensity
  ready_o  out  1  block accepts a sample this cycle
  heat_o / AC_o / dehumidifier_o / blinds_o  out  NUM_ZONES each  per-zone actuator, bit z = zone z
  done_o  out  1  one-cycle pulse: sample processed
  err_o  out  1  one-cycle pulse: sample had zone_i >= NUM_ZONES

Function
REQ-003 FSM states SHALL be OFF, IDLE, CONTROL; ready_o = 1 only in IDLE.
REQ-004 OFF -> IDLE on the first edge with enable_i = 1; any state -> OFF on any edge with enable_i = 0.
REQ-005 Handshake SHALL be valid_i & ready_o at a rising edge; that edge captures zone_i and the three samples and moves IDLE -> CONTROL.
REQ-006 CONTROL -> IDLE on the next edge, which updates the addressed zone's outputs; done_o = 1 for the following cycle; throughput one sample per 2 cycles.
REQ-007 Heater: set when temp < T_HEAT_ON, clear when temp >= T_HEAT_OFF, else unchanged; AC: set when temp >= T_AC_ON, clear when temp <= T_AC_OFF, else unchanged.
REQ-008 Dehumidifier and blinds SHALL use the same set/clear/hold hysteresis with their own thresholds.
REQ-009 Comparisons SHALL be unsigned at the sample's own width; threshold parameters SHALL be truncated to that width.
REQ-010 heat_o[z] and AC_o[z] SHALL never both be 1; if AC is set, heat is cleared in the same update.
REQ-011 Each zone SHALL have a hold counter loaded with MIN_HOLD when any of its outputs changes, decrementing to 0 each cycle.
REQ-012 While a zone's counter is nonzero, samples for that zone SHALL be accepted, produce done_o, and leave outputs unchanged.
REQ-013 zone_i >= NUM_ZONES SHALL be accepted, change no output, and pulse err_o instead of done_o.
REQ-014 On entry to OFF, all actuator outputs, hold counters and capture registers SHALL clear on the same edge; a sample in CONTROL is discarded without done_o.
REQ-015 Zones not addressed by a sample SHALL keep their outputs; their hold counters keep decrementing.

Reset
REQ-016 reset_n = 0 SHALL asynchronously force state OFF and all outputs, counters and capture registers to 0.
REQ-017 After reset_n rises, leaving OFF SHALL require a clock edge with enable_i = 1.

Structure
REQ-018 A shared package ambient_pkg SHALL hold the state enum, default width and threshold constants, and the ZW function.
REQ-019 A sub-module ambient_zone_ch SHALL hold one zone's four actuator bits, hysteresis logic and hold counter; it is instantiated NUM_ZONES times.

Verification
REQ-020 Directed scenarios, one per line:
  reset, enable=1, zone 1, temp 18 hum 40 lum 300 -> heat_o=0010, others 0, done_o 2 cycles after handshake edge
  zone 1 temp 21, >=MIN_HOLD cycles later -> heat_o[1] stays 1 (hysteresis); temp 22 -> heat_o[1]=0
  zone 2 temp 30, then zone 2 temp 10 within 3 cycles -> AC_o[2]=1, second sample done_o, heat_o[2] stays 0
  zone 0 hum 50 lum 700 -> dehumidifier_o[0]=1 and blinds_o[0]=1; hum 36 lum 201 -> both unchanged
  NUM_ZONES=3, zone_i=3 -> err_o pulse, no output change; enable_i=0 during CONTROL -> all outputs 0, no done_o
  reset_n low mid-CONTROL with outputs set -> all outputs 0 immediately (no edge), ready_o=0 until an enable edge
